mp_addsub_cmp: RTL and testbench

- Digit-serial multi-precision arithmetic unit for the RSA datapath. Performs add, subtract or magnitude compare on two WIDTH-bit operands.
- Processes one DIGIT-bit digit per cycle through a single DIGIT-bit adder with a carry flip-flop.
- Generalises the fixed 32-bit/8-bit serial add and compare units to arbitrary width and digit size.
- Adds a start/busy/done handshake, a registered borrow, and a zero flag.

---
 rtl/mp_addsub_cmp.sv | 228 ++++++++++++++++++++++
 tb/tb_mp_addsub_cmp.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mp_addsub_cmp.sv
// ----------------------------------------------------------------------------
// mp_addsub_cmp
//
// Digit-serial multi-precision add / subtract / magnitude compare for the RSA
// datapath. One DIGIT-bit digit is processed per clock through a single
// DIGIT-bit adder and a carry flip-flop, least significant digit first.
//
// Optional build macro: MPARITH_MSB_CMP_EN
//   When defined, compare uses a separate MSB-first digit scan that finishes
//   early at the first unequal digit. Add and sub are unaffected.
//
// Parameters:
//   WIDTH  operand/result width in bits (integer multiple of DIGIT)
//   DIGIT  bits processed per cycle; N = WIDTH/DIGIT >= 2
//
// Ports:
//   clk     clock, rising edge
//   rst     synchronous active-high reset; aborts any operation, no done pulse
//   start   request, accepted only in IDLE
//   op      00 add, 01 sub (ina-inb), 10 compare, 11 executes as add
//   ina     operand A, sampled on the accept cycle only
//   inb     operand B, sampled on the accept cycle only
//   busy    high from the cycle after accept while digits are being processed
//   done    one-cycle pulse when result and flags are valid
//   result  sum/difference mod 2^WIDTH; unchanged by compare
//   cout    add: carry out; sub/compare: borrow (ina < inb, unsigned)
//   g       compare only: ina > inb
//   e       compare only: ina == inb
// ----------------------------------------------------------------------------
module mp_addsub_cmp #(
    parameter int WIDTH = 64,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             g,
    output logic             e
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;

    // Reject unusable geometries at elaboration time.
    generate
        if (((WIDTH % DIGIT) != 0) || ((WIDTH / DIGIT) < 2)) begin : g_bad_params
            $fatal(1, "mp_addsub_cmp: WIDTH must be a multiple of DIGIT with at least 2 digits");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic             carry_q;
    logic             nz_q;
    logic [WIDTH-1:0] acc_q;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             g_q;
    logic             e_q;

    // Combinational digit datapath
    logic             is_sub_d;
    logic             last_d;
    int               lsb_idx_d;
    logic [DIGIT-1:0] a_dig_d;
    logic [DIGIT-1:0] b_dig_d;
    logic [DIGIT:0]   sum_d;

    always_comb begin
        is_sub_d  = (op_q == OP_SUB) || (op_q == OP_CMP);
        last_d    = (cnt_q == CW'(N - 1));
        lsb_idx_d = int'(cnt_q) * DIGIT;
        a_dig_d   = a_q[lsb_idx_d +: DIGIT];
        b_dig_d   = b_q[lsb_idx_d +: DIGIT];
        // Subtraction as a + ~b + 1: the +1 comes from the preloaded carry.
        sum_d     = {1'b0, a_dig_d}
                  + {1'b0, (is_sub_d ? ~b_dig_d : b_dig_d)}
                  + {{DIGIT{1'b0}}, carry_q};
    end

`ifdef MPARITH_MSB_CMP_EN
    logic             cg_q;   // compare outcome gathered during the scan
    logic             ce_q;
    int               msb_idx_d;
    logic [DIGIT-1:0] a_top_d;
    logic [DIGIT-1:0] b_top_d;

    always_comb begin
        msb_idx_d = (N - 1 - int'(cnt_q)) * DIGIT;
        a_top_d   = a_q[msb_idx_d +: DIGIT];
        b_top_d   = b_q[msb_idx_d +: DIGIT];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            nz_q     <= 1'b0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            g_q      <= 1'b0;
            e_q      <= 1'b0;
`ifdef MPARITH_MSB_CMP_EN
            cg_q     <= 1'b0;
            ce_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= ina;
                        b_q     <= inb;
                        op_q    <= op;
                        carry_q <= (op == OP_SUB) || (op == OP_CMP);
                        nz_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`ifdef MPARITH_MSB_CMP_EN
                        cg_q    <= 1'b0;
                        ce_q    <= 1'b1;
`endif
                    end
                end

                RUN: begin
                    cnt_q <= cnt_q + CW'(1);
`ifdef MPARITH_MSB_CMP_EN
                    if (op_q == OP_CMP) begin
                        // The first unequal digit from the top decides the order.
                        if (a_top_d != b_top_d) begin
                            cg_q    <= (a_top_d > b_top_d);
                            ce_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= FIN;
                        end else if (last_d) begin
                            busy_q  <= 1'b0;
                            state_q <= FIN;
                        end
                    end else
`endif
                    begin
                        // Accumulator shifts right so digit 0 lands at the bottom
                        // after N steps.
                        acc_q   <= {sum_d[DIGIT-1:0], acc_q[WIDTH-1:DIGIT]};
                        carry_q <= sum_d[DIGIT];
                        nz_q    <= nz_q | (|sum_d[DIGIT-1:0]);
                        if (last_d) begin
                            busy_q  <= 1'b0;
                            state_q <= FIN;
                        end
                    end
                end

                FIN: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                    case (op_q)
                        OP_CMP: begin
`ifdef MPARITH_MSB_CMP_EN
                            g_q    <= cg_q;
                            e_q    <= ce_q;
                            cout_q <= ~cg_q & ~ce_q;
`else
                            // Final carry of a + ~b + 1 is 1 exactly when a >= b.
                            cout_q <= ~carry_q;
                            e_q    <= ~nz_q;
                            g_q    <= carry_q & nz_q;
`endif
                        end
                        OP_SUB: begin
                            result_q <= acc_q;
                            cout_q   <= ~carry_q;
                        end
                        default: begin
                            result_q <= acc_q;
                            cout_q   <= carry_q;
                        end
                    endcase
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign g      = g_q;
    assign e      = e_q;

endmodule

// File: tb/tb_mp_addsub_cmp.sv
// ----------------------------------------------------------------------------
// tb_mp_addsub_cmp
//
// Self-checking bench for mp_addsub_cmp at WIDTH=32, DIGIT=8. Directed cases
// followed by randomized operations compared against a plain-arithmetic
// reference model. Honours MPARITH_MSB_CMP_EN for compare latency.
// ----------------------------------------------------------------------------
module tb_mp_addsub_cmp;

    localparam int W = 32;
    localparam int D = 8;
    localparam int N = W / D;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] ina;
    logic [W-1:0] inb;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         g;
    logic         e;

    always #5 clk = ~clk;

    mp_addsub_cmp #(
        .WIDTH (W),
        .DIGIT (D)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .ina    (ina),
        .inb    (inb),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .g      (g),
        .e      (e)
    );

    int checks = 0;
    int errs   = 0;

    // Reference model state: what the outputs should hold.
    logic [W-1:0] m_res;
    logic         m_cout;
    logic         m_g;
    logic         m_e;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_res  = '0;
        m_cout = 1'b0;
        m_g    = 1'b0;
        m_e    = 1'b0;
    endtask

    // Updates the expected outputs and returns the expected accept-to-done
    // latency in cycles.
    task automatic model_op(input logic [1:0] o, input logic [W-1:0] a,
                            input logic [W-1:0] b, output int lat);
        logic [W:0] s;
        lat = N + 1;
        case (o)
            2'b10: begin
                m_g    = (a > b);
                m_e    = (a == b);
                m_cout = (a < b);
`ifdef MPARITH_MSB_CMP_EN
                for (int k = 0; k < N; k++) begin
                    if (a[(N-1-k)*D +: D] != b[(N-1-k)*D +: D]) begin
                        lat = k + 2;
                        break;
                    end
                end
`endif
            end
            2'b01: begin
                m_res  = a - b;
                m_cout = (a < b);
            end
            default: begin
                s      = {1'b0, a} + {1'b0, b};
                m_res  = s[W-1:0];
                m_cout = s[W];
            end
        endcase
    endtask

    // Called at #1 after an edge with the DUT idle or in its done cycle.
    // Returns at #1 after the edge where done is observed (or on timeout).
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit hammer, input string name);
        int lat;
        int c;
        int bc;
        start = 1'b1;
        op    = o;
        ina   = a;
        inb   = b;
        @(posedge clk);
        #1;
        chk({name, ".done_pulse"}, 64'(done), 64'd0);
        model_op(o, a, b, lat);
        start = 1'b0;
        op    = 2'($urandom);
        ina   = $urandom;
        inb   = $urandom;
        c  = 0;
        bc = 0;
        while (!done && c < 40) begin
            if (busy) bc++;
            start = hammer && busy;
            if (hammer) begin
                op  = 2'($urandom);
                ina = $urandom;
                inb = $urandom;
            end
            @(posedge clk);
            #1;
            c++;
        end
        start = 1'b0;
        chk({name, ".latency"}, 64'(c), 64'(lat));
        chk({name, ".busy_cycles"}, 64'(bc), 64'(lat - 1));
        chk({name, ".busy_at_done"}, 64'(busy), 64'd0);
        chk({name, ".result"}, 64'(result), 64'(m_res));
        chk({name, ".cout"}, 64'(cout), 64'(m_cout));
        chk({name, ".g"}, 64'(g), 64'(m_g));
        chk({name, ".e"}, 64'(e), 64'(m_e));
        $display("%s op=%0d a=%08h b=%08h -> result=%08h cout=%0d g=%0d e=%0d lat=%0d",
                 name, o, a, b, result, cout, g, e, c);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, ".busy"}, 64'(busy), 64'd0);
        chk({name, ".done"}, 64'(done), 64'd0);
        chk({name, ".result"}, 64'(result), 64'd0);
        chk({name, ".cout"}, 64'(cout), 64'd0);
        chk({name, ".g"}, 64'(g), 64'd0);
        chk({name, ".e"}, 64'(e), 64'd0);
    endtask

    initial begin
        int dcount;
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           mode;
        int           bsel;

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        ina   = '0;
        inb   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b0;

        // Directed cases
        run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "add_wrap");
        run_op(2'b01, 32'h0000_0005, 32'h0000_0007, 1'b0, "sub_borrow");
        run_op(2'b01, 32'h1234_5678, 32'h0234_5677, 1'b0, "sub_plain");
        run_op(2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "cmp_equal");
        run_op(2'b10, 32'h0100_0000, 32'h00FF_FFFF, 1'b0, "cmp_greater");
        run_op(2'b10, 32'h0000_0010, 32'h0000_0011, 1'b0, "cmp_less");
        run_op(2'b00, 32'h0000_0001, 32'h0000_0001, 1'b1, "add_ignore_busy");
        // Issued in the done cycle of the previous op
        run_op(2'b11, 32'h0000_FFFF, 32'h0000_0001, 1'b0, "add_b2b_op3");

        // Reset in the second RUN cycle aborts without a done pulse
        start = 1'b1;
        op    = 2'b00;
        ina   = 32'h1111_1111;
        inb   = 32'h2222_2222;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk_outputs_zero("abort");
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dcount++;
            @(posedge clk);
            #1;
        end
        chk("abort.no_done", 64'(dcount), 64'd0);
        $display("abort reset mid-run: done pulses seen=%0d", dcount);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, "add_after_abort");

        // Randomized operations, all back-to-back
        for (int i = 0; i < 1000; i++) begin
            ro   = 2'($urandom_range(0, 3));
            ra   = $urandom;
            mode = $urandom_range(0, 3);
            bsel = $urandom_range(0, N - 1);
            if (mode == 0) begin
                rb = ra;
            end else if (mode == 1) begin
                rb = ra ^ (W'($urandom_range(1, 255)) << (bsel * D));
            end else begin
                rb = $urandom;
            end
            run_op(ro, ra, rb, ($urandom_range(0, 7) == 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
